merge_sort_param: RTL and testbench

Parametrised successor to the fixed 8×8-bit merge sorter in the BWT datapath. It sorts N unsigned DATA_W-bit elements with a bottom-up, ping-pong merge sort, writing one element per clock. The sort is stable, selectable ascending or descending, and accepts a variable valid length. It optionally reports the original index of every output element, which the BWT stage needs to recover rotation positions.

---
 rtl/merge_sort_param_if.sv | 18 +
 rtl/merge_sort_param.sv | 132 +++++++++++++
 tb/tb_merge_sort_param.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/merge_sort_param_if.sv
// merge_sort_param_if: request/result bundle for merge_sort_param.
// master drives the request side, slave (the sorter) drives results and status.
interface merge_sort_param_if #(
    parameter int DATA_W = 8,
    parameter int N = 8,
    parameter int IDX_W = $clog2(N)
);
    logic start;
    logic descend;
    logic [IDX_W:0] len;
    logic [DATA_W-1:0] data_in [N];
    logic [DATA_W-1:0] data_out [N];
    logic [IDX_W-1:0] idx_out [N];
    logic busy;
    logic done;
    modport master (output start, descend, len, data_in, input data_out, idx_out, busy, done);
    modport slave (input start, descend, len, data_in, output data_out, idx_out, busy, done);
endinterface

// File: rtl/merge_sort_param.sv
// merge_sort_param: stable bottom-up ping-pong merge sorter, one element written per clock.
// Define MERGE_SORT_IDX_EN to carry original indices through the sort onto idx_out.
module merge_sort_param #(
    parameter int DATA_W = 8,
    parameter int N = 8,
    parameter int IDX_W = $clog2(N)
) (
    input logic clk,
    input logic rst,
    merge_sort_param_if.slave sb
);
    typedef enum logic [1:0] {IDLE, MERGE, OUT} state_t;
    localparam logic [IDX_W:0] ONE = 1;
    state_t state, state_nx;
    logic [DATA_W-1:0] a_d [N];
    logic [DATA_W-1:0] b_d [N];
    logic [DATA_W-1:0] dout [N];
    logic [IDX_W-1:0] k, w, li, ri, base, lp, rp;
    logic [IDX_W:0] len_q, w2;
    logic desc_q, sel, busy_q, done_q;
    logic pad_l, pad_r, take_l, blk_end, last;
    logic [DATA_W-1:0] dl, dr, wd;

    // Stable merging keeps every pad after the valid elements, so "position >= len"
    // identifies pads on every pass without storing a flag per element.
    always_comb begin
        w2 = {1'b0, w} << 1;
        base = IDX_W'({1'b0, k} & ~(w2 - ONE));
        lp = base + li;
        rp = base + w + ri;
        dl = sel ? b_d[lp] : a_d[lp];
        dr = sel ? b_d[rp] : a_d[rp];
        pad_l = {1'b0, lp} >= len_q;
        pad_r = {1'b0, rp} >= len_q;
        take_l = (ri == w) || (li != w && (pad_r || (!pad_l && (desc_q ? dl >= dr : dl <= dr))));
        wd = take_l ? dl : dr;
        blk_end = (({1'b0, k} + ONE) & (w2 - ONE)) == '0;
        last = k == IDX_W'(N - 1) && w == IDX_W'(N / 2);
    end

    always_comb begin
        state_nx = state == IDLE ? (sb.start ? MERGE : IDLE) :
                   state == MERGE ? (last ? OUT : MERGE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int x = 0; x < N; x++) begin
                a_d[x] <= '0;
                b_d[x] <= '0;
                dout[x] <= '0;
            end
            k <= '0;
            w <= '0;
            li <= '0;
            ri <= '0;
            len_q <= '0;
            desc_q <= 1'b0;
            sel <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE && sb.start) begin
                for (int x = 0; x < N; x++) a_d[x] <= sb.data_in[x];
                len_q <= (sb.len == '0 || sb.len > (IDX_W + 1)'(N)) ? (IDX_W + 1)'(N) : sb.len;
                desc_q <= sb.descend;
                sel <= 1'b0;
                k <= '0;
                w <= IDX_W'(1);
                li <= '0;
                ri <= '0;
                busy_q <= 1'b1;
            end else if (state == MERGE) begin
                if (sel) a_d[k] <= wd;
                else b_d[k] <= wd;
                k <= k + IDX_W'(1);
                li <= blk_end ? '0 : (take_l ? li + IDX_W'(1) : li);
                ri <= blk_end ? '0 : (take_l ? ri : ri + IDX_W'(1));
                if (k == IDX_W'(N - 1)) begin
                    sel <= !sel;
                    w <= w << 1;
                end
            end else if (state == OUT) begin
                for (int x = 0; x < N; x++) dout[x] <= sel ? b_d[x] : a_d[x];
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    assign sb.data_out = dout;
    assign sb.busy = busy_q;
    assign sb.done = done_q;

`ifdef MERGE_SORT_IDX_EN
    logic [IDX_W-1:0] a_i [N];
    logic [IDX_W-1:0] b_i [N];
    logic [IDX_W-1:0] iout [N];
    logic [IDX_W-1:0] wi;

    always_comb begin
        wi = take_l ? (sel ? b_i[lp] : a_i[lp]) : (sel ? b_i[rp] : a_i[rp]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int x = 0; x < N; x++) begin
                a_i[x] <= '0;
                b_i[x] <= '0;
                iout[x] <= '0;
            end
        end else if (state == IDLE && sb.start) begin
            for (int x = 0; x < N; x++) a_i[x] <= IDX_W'(x);
        end else if (state == MERGE) begin
            if (sel) a_i[k] <= wi;
            else b_i[k] <= wi;
        end else if (state == OUT) begin
            for (int x = 0; x < N; x++) iout[x] <= sel ? b_i[x] : a_i[x];
        end
    end

    assign sb.idx_out = iout;
`else
    assign sb.idx_out = '{default: '0};
`endif
endmodule

// File: tb/tb_merge_sort_param.sv
// tb_merge_sort_param: directed and random runs of an 8x8 and a 16x4 sorter against a rank-based reference.
module tb_merge_sort_param;
    logic clk, rst;
    int checks, errors;
    logic [7:0] in_d [16];
    logic [7:0] exp_d [16];
    int exp_i [16];

    merge_sort_param_if #(.DATA_W(8), .N(8)) b8 ();
    merge_sort_param_if #(.DATA_W(4), .N(16)) b16 ();

    merge_sort_param #(.DATA_W(8), .N(8)) u8 (.clk(clk), .rst(rst), .sb(b8));
    merge_sort_param #(.DATA_W(4), .N(16)) u16 (.clk(clk), .rst(rst), .sb(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output position of element i = number of elements that must precede it.
    task automatic model(input int n, input int ln, input bit ds);
        int l, r;
        l = (ln == 0 || ln > n) ? n : ln;
        for (int i = 0; i < n; i++) begin
            r = i;
            if (i < l) begin
                r = 0;
                for (int j = 0; j < l; j++)
                    if ((ds ? in_d[j] > in_d[i] : in_d[j] < in_d[i]) || (in_d[j] == in_d[i] && j < i)) r++;
            end
            exp_d[r] = in_d[i];
            exp_i[r] = i;
        end
    endtask

    function automatic logic [31:0] eidx(input int r);
`ifdef MERGE_SORT_IDX_EN
        return exp_i[r];
`else
        return 0;
`endif
    endfunction

    task automatic load_str(input string s);
        for (int i = 0; i < 16; i++) in_d[i] = i < s.len() ? s[i] : 8'h00;
    endtask

    task automatic go8(input int ln, input bit ds, input int glitch);
        int cnt;
        model(8, ln, ds);
        for (int i = 0; i < 8; i++) b8.data_in[i] = in_d[i];
        b8.len = 4'(ln);
        b8.descend = ds;
        b8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
        chk("busy8_on", b8.busy, 1);
        cnt = 0;
        while (cnt < 100 && b8.done !== 1'b1) begin
            if (cnt == glitch - 1) begin
                b8.start = 1'b1;
                for (int i = 0; i < 8; i++) b8.data_in[i] = 8'("h" - i);
                b8.descend = !ds;
                b8.len = 4'd2;
            end else b8.start = 1'b0;
            @(negedge clk);
            cnt++;
        end
        b8.start = 1'b0;
        chk("lat8", cnt, 25);
        chk("busy8_off", b8.busy, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("d8[%0d]", i), b8.data_out[i], exp_d[i]);
            chk($sformatf("i8[%0d]", i), b8.idx_out[i], eidx(i));
        end
        @(negedge clk);
        chk("done8_fall", b8.done, 0);
    endtask

    task automatic go16(input int ln, input bit ds);
        int cnt;
        for (int i = 0; i < 16; i++) in_d[i] = in_d[i] & 8'h0f;
        model(16, ln, ds);
        for (int i = 0; i < 16; i++) b16.data_in[i] = in_d[i][3:0];
        b16.len = 5'(ln);
        b16.descend = ds;
        b16.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b16.start = 1'b0;
        chk("busy16_on", b16.busy, 1);
        cnt = 0;
        while (cnt < 200 && b16.done !== 1'b1) begin
            @(negedge clk);
            cnt++;
        end
        chk("lat16", cnt, 65);
        chk("busy16_off", b16.busy, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("d16[%0d]", i), b16.data_out[i], exp_d[i]);
            chk($sformatf("i16[%0d]", i), b16.idx_out[i], eidx(i));
        end
        @(negedge clk);
        chk("done16_fall", b16.done, 0);
    endtask

    initial begin
        int extra;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        b8.start = 1'b0;
        b8.descend = 1'b0;
        b8.len = '0;
        b16.start = 1'b0;
        b16.descend = 1'b0;
        b16.len = '0;
        for (int i = 0; i < 8; i++) b8.data_in[i] = '0;
        for (int i = 0; i < 16; i++) b16.data_in[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy8", b8.busy, 0);
        chk("rst_done8", b8.done, 0);
        chk("rst_busy16", b16.busy, 0);
        for (int i = 0; i < 8; i++) begin
            chk("rst_d8", b8.data_out[i], 0);
            chk("rst_i8", b8.idx_out[i], 0);
        end
        rst = 1'b1;
        @(negedge clk);

        load_str("cadbabab");
        go8(8, 1'b0, -1);
        load_str("babacdaf");
        go8(8, 1'b1, -1);
        load_str("twoab");
        go8(5, 1'b0, -1);

        load_str("cadbabab");
        go8(8, 1'b0, 5);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (b8.done === 1'b1) extra++;
        end
        chk("single_done", extra, 0);

        load_str("cadbabab");
        for (int i = 0; i < 8; i++) b8.data_in[i] = in_d[i];
        b8.len = 4'd8;
        b8.descend = 1'b0;
        b8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", b8.busy, 0);
        chk("arst_done", b8.done, 0);
        for (int i = 0; i < 8; i++) begin
            chk("arst_d8", b8.data_out[i], 0);
            chk("arst_i8", b8.idx_out[i], 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_str("babacdaf");
        go8(8, 1'b1, -1);

        for (int i = 0; i < 16; i++) in_d[i] = 8'h05;
        in_d[9] = 8'h01;
        go16(16, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) in_d[i] = 8'($urandom_range(0, 255));
            if (t < 3) for (int i = 0; i < 8; i++) in_d[i] = 8'($urandom_range(97, 100));
            go8(int'($urandom_range(0, 12)), 1'($urandom), -1);
        end
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) in_d[i] = 8'($urandom_range(0, 3));
            go16(int'($urandom_range(0, 20)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
